max7219_rx: RTL

Receiver for the MAX7219 serial protocol (DIN / CLK / LOAD) that `led7219` drives on exp2_15..17. It decodes 16-bit frames into the MAX7219 register file: digits 0..7, decode mode, intensity, scan limit, shutdown and display test. It exposes that register file as parallel outputs, plus a cascade output for daisy-chaining. Its roles are the loopback checker for the LED debug path on the board and the display model in Verilator benches.

---
 rtl/max7219_rx_pkg.sv | 18 +
 rtl/max7219_rx_if.sv | 10 +
 rtl/max7219_rx_sync_edge.sv | 29 ++
 rtl/max7219_rx.sv | 98 +++++++++
 4 files changed

// File: rtl/max7219_rx_pkg.sv
// Shared constants for the MAX7219 receiver: register addresses and frame length.
package max7219_pkg;
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;
  localparam logic [4:0] FRAME_BITS     = 5'd16;
endpackage

// File: rtl/max7219_rx_if.sv
// Serial MAX7219 link: DIN, CLK and LOAD from the driver, cascade DOUT back.
interface max7219_rx_if;
  logic leds_in;
  logic leds_clk;
  logic leds_cs;
  logic leds_dout;

  modport master (output leds_in, output leds_clk, output leds_cs, input leds_dout);
  modport slave  (input leds_in, input leds_clk, input leds_cs, output leds_dout);
endinterface

// File: rtl/max7219_rx_sync_edge.sv
// Multi-stage synchronizer with one extra register for rise/fall detection.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign q    = stages[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/max7219_rx.sv
// MAX7219 serial receiver: shifts DIN on CLK rises, commits 16-bit frames on
// LOAD rise into a parallel register file, and replays overflow bits on DOUT.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  max7219_rx_if.slave         bus,
  output logic [63:0]         digits,
  output logic [7:0]          decode_mode,
  output logic [3:0]          intensity,
  output logic [2:0]          scan_limit,
  output logic                shutdown,
  output logic                display_test,
  output logic                wr_strobe,
  output logic [3:0]          wr_addr,
  output logic [7:0]          wr_data,
  output logic                frame_error
);
  logic din_q, din_rise, din_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;

  logic [15:0] shreg;
  logic [4:0]  bitcnt;
  logic        dout_q;
  logic [3:0]  f_addr;
  logic [7:0]  f_data;
  logic [2:0]  dig_idx;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(clk), .rst(rst), .d(bus.leds_in), .q(din_q), .rise(din_rise), .fall(din_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(bus.leds_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  // LOAD resets high so releasing rst never looks like a commit edge.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(bus.leds_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

  assign f_addr  = shreg[11:8];
  assign f_data  = shreg[7:0];
  // Addresses 1..8 map to digits 0..7; address 8 wraps to index 7.
  assign dig_idx = f_addr[2:0] - 3'd1;
  assign bus.leds_dout = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg        <= '0;
      bitcnt       <= '0;
      dout_q       <= 1'b0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown     <= 1'b1;
      display_test <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_error  <= 1'b0;
    end else begin
      wr_strobe   <= 1'b0;
      frame_error <= 1'b0;
      if (cs_rise) begin
        // cs_q is already high here, so a coincident CLK rise is dropped.
        if (bitcnt == FRAME_BITS) begin
          wr_strobe <= 1'b1;
          wr_addr   <= f_addr;
          wr_data   <= f_data;
          case (f_addr)
            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
              digits[{dig_idx, 3'b000} +: 8] <= f_data;
            ADDR_DECODE:    decode_mode  <= f_data;
            ADDR_INTENSITY: intensity    <= f_data[3:0];
            ADDR_SCANLIM:   scan_limit   <= f_data[2:0];
            ADDR_SHUTDOWN:  shutdown     <= ~f_data[0];
            ADDR_TEST:      display_test <= f_data[0];
            default: ;
          endcase
        end else if (bitcnt != 5'd0) begin
          frame_error <= 1'b1;
        end
        bitcnt <= '0;
      end else if (cs_fall) begin
        bitcnt <= '0;
      end else if (sclk_rise && !cs_q) begin
        dout_q <= shreg[15];
        shreg  <= {shreg[14:0], din_q};
        if (bitcnt != FRAME_BITS) bitcnt <= bitcnt + 5'd1;
      end
    end
  end

  logic unused_edges;
  assign unused_edges = din_rise ^ din_fall ^ sclk_q ^ sclk_fall;
endmodule
